// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: sequences CPU load/store accesses onto a byte-wide data memory, one byte
// per cycle, little-endian. Loads are assembled and sign/zero-extended; completion is a
// one-cycle done pulse, and busy (accept through done) stalls the pipeline.
//
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned half/word accesses. These
// skip the memory transfer and complete at once with err=1 and rdata=0. When the macro is
// undefined, misaligned accesses run byte-wise and err is tied to 0.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req, we, funct3     request (sampled in idle), store/load select, RV32I size/sign code
//   addr, wdata         lowest byte address, store data (all latched at accept)
//   rdata, done, busy   load result (held until next accept), completion pulse, stall
//   err                 misalignment flag, same timing as done
//   mem_addr/_wdata/_we memory byte port (address held outside transfers)
//   mem_rdata           memory read byte, combinational from mem_addr
module data_mem_ctrl #(
  parameter int unsigned ADDRESS = 8,
  parameter int unsigned WIDTH   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
  input  logic               we,
  input  logic [2:0]         funct3,
  input  logic [ADDRESS-1:0] addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               done,
  output logic               busy,
  output logic               err,
  output logic [ADDRESS-1:0] mem_addr,
  output logic [WIDTH-1:0]   mem_wdata,
  output logic               mem_we,
  input  logic [WIDTH-1:0]   mem_rdata
);

  if (WIDTH != 8) begin : g_width_check
    $error("data_mem_ctrl: WIDTH must be 8");
  end

  typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

  state_e             state_q, state_d;
  logic               we_q, we_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [ADDRESS-1:0] addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [1:0]         k_q, k_d;
  logic [31:0]        raw_q, raw_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [ADDRESS-1:0] last_addr_q, last_addr_d;

  logic [ADDRESS-1:0] cur_addr;
  logic [7:0]         cur_byte;
  logic [1:0]         last_k;

  // Sign- or zero-extend the assembled little-endian load value to 32 bits.
  function automatic logic [31:0] load_ext(input logic [31:0] raw, input logic [2:0] f3);
    logic [31:0] res;
    case (f3[1:0])
      2'b00:   res = f3[2] ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'b01:   res = f3[2] ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   last_k = 2'd0;
      2'b01:   last_k = 2'd1;
      default: last_k = 2'd3;
    endcase
    case (k_q)
      2'd0:    cur_byte = wdata_q[7:0];
      2'd1:    cur_byte = wdata_q[15:8];
      2'd2:    cur_byte = wdata_q[23:16];
      default: cur_byte = wdata_q[31:24];
    endcase
  end

  // Address arithmetic wraps naturally at 2**ADDRESS.
  assign cur_addr = addr_q + ADDRESS'(k_q);

`ifdef MISALIGN_TRAP_EN
  logic err_q, err_d;
  logic misaligned;
  assign misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                      (funct3[1] && (addr[1:0] != 2'b00));
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    k_d         = k_q;
    raw_d       = raw_q;
    rdata_d     = rdata_q;
    last_addr_d = last_addr_q;
`ifdef MISALIGN_TRAP_EN
    err_d       = err_q;
`endif
    mem_we      = 1'b0;
    mem_wdata   = '0;
    mem_addr    = last_addr_q;

    case (state_q)
      StIdle: begin
        if (req) begin
          we_d     = we;
          funct3_d = funct3;
          addr_d   = addr;
          wdata_d  = wdata;
          k_d      = 2'd0;
          raw_d    = '0;
          rdata_d  = '0;
          state_d  = StXfer;
`ifdef MISALIGN_TRAP_EN
          if (misaligned) begin
            state_d = StDone;
            err_d   = 1'b1;
          end
`endif
        end
      end
      StXfer: begin
        mem_addr    = cur_addr;
        last_addr_d = cur_addr;
        if (we_q) begin
          mem_we    = 1'b1;
          mem_wdata = cur_byte;
        end else begin
          raw_d = raw_q | ({24'b0, mem_rdata} << {k_q, 3'b000});
        end
        if (k_q == last_k) begin
          state_d = StDone;
          // Stores leave rdata at the zero written at accept.
          if (!we_q) begin
            rdata_d = load_ext(raw_d, funct3_q);
          end
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
`ifdef MISALIGN_TRAP_EN
        err_d   = 1'b0;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      funct3_q    <= 3'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      k_q         <= 2'd0;
      raw_q       <= '0;
      rdata_q     <= '0;
      last_addr_q <= '0;
`ifdef MISALIGN_TRAP_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      k_q         <= k_d;
      raw_q       <= raw_d;
      rdata_q     <= rdata_d;
      last_addr_q <= last_addr_d;
`ifdef MISALIGN_TRAP_EN
      err_q       <= err_d;
`endif
    end
  end

  assign rdata = rdata_q;
  assign done  = (state_q == StDone);
  assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: the driver pushes expected completions and memory
// writes computed from a byte-array reference model; a negedge monitor pops and compares.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [7:0]  addr = 8'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        done, busy, err;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  data_mem_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .we        (we),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .done      (done),
    .busy      (busy),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  exp_t       eq[$];
  wr_t        wq[$];
  logic [7:0] ref_mem [256];
  logic [7:0] tb_mem [256];
  bit         mem_loaded = 1'b0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         last_done_cyc = 0;
  bit         prev_hold = 1'b0;

  // Memory environment: async read, sync write; loaded once from the reference image.
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= ref_mem[i];
      mem_loaded <= 1'b1;
    end else if (mem_we) begin
      tb_mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = tb_mem[mem_addr];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every write and every completion against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write",
                   mem_addr, mem_wdata);
        end else begin
          wr_t w;
          w = wq.pop_front();
          chk("write_addr", {24'b0, mem_addr}, {24'b0, w.a});
          chk("write_data", {24'b0, mem_wdata}, {24'b0, w.d});
        end
      end
      if (err && !done) begin
        checks++;
        errors++;
        $display("FAIL err_without_done: got err 1 expected 0");
      end
      if (done) begin
        if (eq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done 1 expected 0");
        end else begin
          exp_t e;
          e = eq.pop_front();
          chk("rdata", rdata, e.rdata);
          chk("err", {31'b0, err}, {31'b0, e.err});
          chk("done_cycle", cyc, e.cyc);
          chk("busy_in_done", {31'b0, busy}, 32'd1);
        end
        last_done_cyc = cyc;
      end
    end
  end

  // Issue one access; expected results come from the reference byte array.
  task automatic access(input logic w, input logic [2:0] f3, input logic [7:0] a,
                        input logic [31:0] wd, input bit hold);
    int      n;
    int      guard;
    bit      mis;
    exp_t    e;
    longint  v;
    logic [7:0] idx;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy 1 expected 0");
    end
    if (prev_hold) chk("b2b_gap", cyc + 1, last_done_cyc + 2);
    we = w;
    funct3 = f3;
    addr = a;
    wdata = wd;
    req = 1'b1;
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
`ifdef MISALIGN_TRAP_EN
    mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    e.err = mis;
    e.rdata = 32'h0;
    if (mis) begin
      e.cyc = cyc + 1;
    end else begin
      e.cyc = cyc + 1 + n;
      v = 0;
      for (int i = 0; i < n; i++) begin
        idx = a + 8'(i);
        if (w) begin
          ref_mem[idx] = wd[8*i +: 8];
          wq.push_back('{a: idx, d: wd[8*i +: 8]});
        end else begin
          v = v + (longint'(ref_mem[idx]) << (8 * i));
        end
      end
      if (!w) begin
        if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        e.rdata = v[31:0];
      end
    end
    eq.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) req = 1'b0;
    prev_hold = hold;
  endtask

  initial begin
    int   g;
    int   bad;
    logic [7:0] rb;
    for (int i = 0; i < 256; i++) begin
      rb = 8'($urandom);
      ref_mem[i] = rb;
    end
    #23;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_mem_we", {31'b0, mem_we}, 32'd0);
    chk("reset_mem_addr", {24'b0, mem_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    access(1'b1, 3'b010, 8'h10, 32'hDEADBEEF, 1'b0);  // sw
    access(1'b0, 3'b000, 8'h13, 32'h0, 1'b0);         // lb
    access(1'b0, 3'b100, 8'h13, 32'h0, 1'b0);         // lbu
    access(1'b1, 3'b001, 8'h20, 32'h12348001, 1'b0);  // sh
    access(1'b0, 3'b001, 8'h20, 32'h0, 1'b0);         // lh
    access(1'b0, 3'b101, 8'h20, 32'h0, 1'b0);         // lhu
    access(1'b1, 3'b010, 8'hFE, 32'h11223344, 1'b0);  // sw with wrap
    access(1'b0, 3'b010, 8'hFE, 32'h0, 1'b1);         // back-to-back lw, req held
    access(1'b0, 3'b010, 8'h10, 32'h0, 1'b1);
    access(1'b0, 3'b011, 8'h20, 32'h0, 1'b0);
    access(1'b0, 3'b010, 8'h01, 32'h0, 1'b0);         // misaligned lw
    access(1'b1, 3'b010, 8'h31, 32'hCAFEF00D, 1'b0);  // misaligned sw

    // Reset in the middle of a word store: only two bytes may land.
    @(negedge clk);
    while (busy) @(negedge clk);
    we = 1'b1;
    funct3 = 3'b010;
    addr = 8'h40;
    wdata = 32'hA5B6C7D8;
    req = 1'b1;
    ref_mem[8'h40] = 8'hD8;
    ref_mem[8'h41] = 8'hC7;
    wq.push_back('{a: 8'h40, d: 8'hD8});
    wq.push_back('{a: 8'h41, d: 8'hC7});
    @(posedge clk);
    #1;
    req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_wdata", {24'b0, mem_wdata}, 32'd0);
    chk("rst_mem_addr", {24'b0, mem_addr}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    prev_hold = 1'b0;
    access(1'b0, 3'b010, 8'h40, 32'h0, 1'b0);

    for (int t = 0; t < 80; t++) begin
      access(1'($urandom), 3'($urandom), 8'($urandom), $urandom, (t != 79) && ($urandom_range(0, 3) == 0));
    end

    g = 0;
    while ((eq.size() != 0 || wq.size() != 0) && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("pending_done", eq.size(), 32'd0);
    chk("pending_writes", wq.size(), 32'd0);
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 256; i++) if (tb_mem[i] !== ref_mem[i]) bad++;
    chk("mem_image", bad, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
